// File: rtl/clock_time_counter_pkg.sv
// Shared constants and BCD helpers for the digital clock timekeeping core.
// Holds the field width, per-field BCD limits and the increment/12-hour mapping functions.
package clock_time_counter_pkg;

  localparam int FIELD_W = 8;

  localparam logic [FIELD_W-1:0] SEC_MAX  = 8'h59;
  localparam logic [FIELD_W-1:0] MIN_MAX  = 8'h59;
  localparam logic [FIELD_W-1:0] HOUR_MAX = 8'h23;

  // Advance a two-digit BCD value by one, wrapping to 00 after lim.
  function automatic logic [FIELD_W-1:0] bcd_next(input logic [FIELD_W-1:0] v,
                                                  input logic [FIELD_W-1:0] lim);
    logic [FIELD_W-1:0] r;
    if (v == lim)
      r = '0;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  // Map a 24-hour BCD hour onto the 12-hour face: 00 -> 12, 13..23 -> 01..11.
  function automatic logic [FIELD_W-1:0] hour_to_12(input logic [FIELD_W-1:0] h24);
    logic [FIELD_W-1:0] r;
    case (h24)
      8'h00:   r = 8'h12;
      8'h13:   r = 8'h01;
      8'h14:   r = 8'h02;
      8'h15:   r = 8'h03;
      8'h16:   r = 8'h04;
      8'h17:   r = 8'h05;
      8'h18:   r = 8'h06;
      8'h19:   r = 8'h07;
      8'h20:   r = 8'h08;
      8'h21:   r = 8'h09;
      8'h22:   r = 8'h10;
      8'h23:   r = 8'h11;
      default: r = h24;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/clock_time_counter_bcd_mod_counter.sv
// Two-digit BCD modulo counter used for the seconds, minutes and hours fields.
// clr has priority over inc; wrap_o flags an increment taken while sitting at MAX_BCD.
module bcd_mod_counter
  import clock_time_counter_pkg::*;
#(
  parameter logic [FIELD_W-1:0] MAX_BCD = 8'h59
) (
  input  logic               ck,
  input  logic               sysreset,
  input  logic               clr,
  input  logic               inc,
  output logic [FIELD_W-1:0] value_o,
  output logic               wrap_o
);

  logic [FIELD_W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (clr)
      value_d = '0;
    else if (inc)
      value_d = bcd_next(value_q, MAX_BCD);
  end

  always_ff @(posedge ck or posedge sysreset) begin
    if (sysreset)
      value_q <= '0;
    else
      value_q <= value_d;
  end

  assign value_o = value_q;
  assign wrap_o  = inc & (value_q == MAX_BCD);

endmodule

// File: rtl/clock_time_counter.sv
// Clock timekeeping core: 1 Hz prescaler, set-command edge detect and BCD h:m:s counters.
// Define HOUR12_EN to present hour_bcd as 12-hour time with a registered pm flag.
module clock_time_counter
  import clock_time_counter_pkg::*;
#(
  parameter int DIV = 1000,
  parameter int PW  = 10
) (
  input  logic               ck,
  input  logic               sysreset,
  input  logic               sec_reset,
  input  logic               min_inc,
  input  logic               hour_inc,
  output logic [FIELD_W-1:0] sec_bcd,
  output logic [FIELD_W-1:0] min_bcd,
  output logic [FIELD_W-1:0] hour_bcd,
  output logic               tick_1hz,
  output logic               blink,
  output logic               pm
);

  logic [PW-1:0]      presc_q, presc_d;
  logic               tick_q, tick_d;
  logic               sec_reset_prev_q, min_inc_prev_q, hour_inc_prev_q;
  logic               sec_clr, min_edge, hour_edge;
  logic               presc_top;
  logic               sec_adv, sec_carry;
  logic               min_adv, min_wrap;
  logic               hour_carry, hour_adv, hour_wrap;
  logic [FIELD_W-1:0] hour_q;

  // Inputs are already in the ck domain; one history flop per command is enough.
  assign sec_clr   = sec_reset & ~sec_reset_prev_q;
  assign min_edge  = min_inc   & ~min_inc_prev_q;
  assign hour_edge = hour_inc  & ~hour_inc_prev_q;

  assign presc_top = (presc_q == PW'(DIV - 1));

  // A seconds clear restarts the second, so it also swallows a tick due this cycle.
  always_comb begin
    presc_d = presc_top ? '0 : presc_q + PW'(1);
    tick_d  = presc_top & ~sec_clr;
    if (sec_clr)
      presc_d = '0;
  end

  always_ff @(posedge ck or posedge sysreset) begin
    if (sysreset) begin
      presc_q          <= '0;
      tick_q           <= 1'b0;
      sec_reset_prev_q <= 1'b0;
      min_inc_prev_q   <= 1'b0;
      hour_inc_prev_q  <= 1'b0;
    end else begin
      presc_q          <= presc_d;
      tick_q           <= tick_d;
      sec_reset_prev_q <= sec_reset;
      min_inc_prev_q   <= min_inc;
      hour_inc_prev_q  <= hour_inc;
    end
  end

  assign tick_1hz = tick_q;
  assign blink    = (presc_q < PW'(DIV / 2));

  assign sec_adv = tick_q & ~sec_clr;

  bcd_mod_counter #(.MAX_BCD(SEC_MAX)) u_sec (
    .ck       (ck),
    .sysreset (sysreset),
    .clr      (sec_clr),
    .inc      (sec_adv),
    .value_o  (sec_bcd),
    .wrap_o   (sec_carry)
  );

  // Carry and manual edge merge into one step; only a carry-driven wrap reaches hours.
  assign min_adv = sec_carry | min_edge;

  bcd_mod_counter #(.MAX_BCD(MIN_MAX)) u_min (
    .ck       (ck),
    .sysreset (sysreset),
    .clr      (1'b0),
    .inc      (min_adv),
    .value_o  (min_bcd),
    .wrap_o   (min_wrap)
  );

  assign hour_carry = min_wrap & sec_carry;
  assign hour_adv   = hour_carry | hour_edge;

  bcd_mod_counter #(.MAX_BCD(HOUR_MAX)) u_hour (
    .ck       (ck),
    .sysreset (sysreset),
    .clr      (1'b0),
    .inc      (hour_adv),
    .value_o  (hour_q),
    .wrap_o   (hour_wrap)
  );

`ifdef HOUR12_EN
  logic pm_q, pm_d;

  // pm follows the internal 24-hour count: set on 11 -> 12, cleared on 23 -> 00.
  always_comb begin
    pm_d = pm_q;
    if (hour_wrap)
      pm_d = 1'b0;
    else if (hour_adv && (hour_q == 8'h11))
      pm_d = 1'b1;
  end

  always_ff @(posedge ck or posedge sysreset) begin
    if (sysreset)
      pm_q <= 1'b0;
    else
      pm_q <= pm_d;
  end

  assign hour_bcd = hour_to_12(hour_q);
  assign pm       = pm_q;
`else
  logic day_wrap_unused;
  assign day_wrap_unused = hour_wrap;
  assign hour_bcd        = hour_q;
  assign pm              = 1'b0;
`endif

endmodule

// File: tb/tb_clock_time_counter.sv
// Self-checking bench for clock_time_counter (DIV=4): per-cycle reference model,
// preload table, hand-written corner sequences and randomized command traffic.
module tb_clock_time_counter;

  localparam int DIV = 4;
  localparam int PW  = 2;

  logic       ck = 1'b0;
  logic       sysreset = 1'b1;
  logic       sec_reset = 1'b0, min_inc = 1'b0, hour_inc = 1'b0;
  logic [7:0] sec_bcd, min_bcd, hour_bcd;
  logic       tick_1hz, blink, pm;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state in plain integers.
  int m_sec, m_min, m_hour, m_presc;
  bit m_tick;
  bit p_s, p_m, p_h;

  always #5 ck = ~ck;

  clock_time_counter #(.DIV(DIV), .PW(PW)) dut (
    .ck        (ck),
    .sysreset  (sysreset),
    .sec_reset (sec_reset),
    .min_inc   (min_inc),
    .hour_inc  (hour_inc),
    .sec_bcd   (sec_bcd),
    .min_bcd   (min_bcd),
    .hour_bcd  (hour_bcd),
    .tick_1hz  (tick_1hz),
    .blink     (blink),
    .pm        (pm)
  );

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  function automatic logic [7:0] disp_hour(input int h);
`ifdef HOUR12_EN
    int d;
    d = h % 12;
    if (d == 0) d = 12;
    return to_bcd(d);
`else
    return to_bcd(h);
`endif
  endfunction

  function automatic bit disp_pm(input int h);
`ifdef HOUR12_EN
    return h >= 12;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [7:0] disp_bcd_hour(input logic [7:0] h24);
    return disp_hour(int'(h24[7:4]) * 10 + int'(h24[3:0]));
  endfunction

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check8("model_sec",  sec_bcd,  to_bcd(m_sec));
    check8("model_min",  min_bcd,  to_bcd(m_min));
    check8("model_hour", hour_bcd, disp_hour(m_hour));
    check1("model_tick", tick_1hz, m_tick);
    check1("model_blink", blink, m_presc < DIV / 2);
    check1("model_pm",   pm, disp_pm(m_hour));
  endtask

  task automatic model_reset();
    m_sec = 0; m_min = 0; m_hour = 0; m_presc = 0; m_tick = 0;
    p_s = 0; p_m = 0; p_h = 0;
  endtask

  // One rising edge of the clock as seen from the time-of-day rules.
  task automatic model_edge();
    bit se, me, he, adv, scar, hcar;
    se = sec_reset & ~p_s;
    me = min_inc & ~p_m;
    he = hour_inc & ~p_h;
    p_s = sec_reset; p_m = min_inc; p_h = hour_inc;
    adv  = m_tick && !se;
    scar = adv && (m_sec == 59);
    m_tick  = (m_presc == DIV - 1) && !se;
    m_presc = se ? 0 : (m_presc + 1) % DIV;
    if (se) m_sec = 0;
    else if (adv) m_sec = (m_sec + 1) % 60;
    hcar = 0;
    if (scar || me) begin
      hcar  = scar && (m_min == 59);
      m_min = (m_min + 1) % 60;
    end
    if (hcar || he) m_hour = (m_hour + 1) % 24;
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge ck);
      model_edge();
      #1;
      check_model();
    end
  endtask

  // Reset is raised mid-cycle so its asynchronous effect is visible before any edge.
  task automatic do_reset();
    @(negedge ck);
    #2;
    sysreset = 1'b1;
    sec_reset = 1'b0; min_inc = 1'b0; hour_inc = 1'b0;
    #1;
    model_reset();
    check_model();
    @(negedge ck);
    sysreset = 1'b0;
  endtask

  // Leaves the clock at h:m:s with the prescaler just past a tick (value 1).
  task automatic preload(input int h, input int m, input int s);
    do_reset();
    for (int i = 0; i < h; i++) begin
      hour_inc = 1'b1; step(); hour_inc = 1'b0; step();
    end
    for (int i = 0; i < m; i++) begin
      min_inc = 1'b1; step(); min_inc = 1'b0; step();
    end
    sec_reset = 1'b1; step(); sec_reset = 1'b0;
    step(4 * s + 1);
  endtask

  typedef struct {
    int         h, m, s, ticks;
    logic [7:0] eh, em, es;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{23, 59, 58,  2, 8'h00, 8'h00, 8'h00};
    tbl[1] = '{10, 15, 59,  1, 8'h10, 8'h16, 8'h00};
    tbl[2] = '{ 9, 59, 59,  1, 8'h10, 8'h00, 8'h00};
    tbl[3] = '{19, 59, 59,  1, 8'h20, 8'h00, 8'h00};
    tbl[4] = '{ 0,  0,  9,  1, 8'h00, 8'h00, 8'h10};
    tbl[5] = '{ 5, 30,  0, 60, 8'h05, 8'h31, 8'h00};
    tbl[6] = '{12, 34, 50,  3, 8'h12, 8'h34, 8'h53};

    // Free run from reset: the 60th tick lands after edge 240, seconds roll on edge 241.
    do_reset();
    step(241);
    check8("run_sec", sec_bcd, 8'h00);
    check8("run_min", min_bcd, 8'h01);
    check8("run_hour", hour_bcd, disp_bcd_hour(8'h00));

    for (int k = 0; k < 7; k++) begin
      preload(tbl[k].h, tbl[k].m, tbl[k].s);
      step(4 * tbl[k].ticks);
      check8("tbl_sec", sec_bcd, tbl[k].es);
      check8("tbl_min", min_bcd, tbl[k].em);
      check8("tbl_hour", hour_bcd, disp_bcd_hour(tbl[k].eh));
    end

    // Held min_inc at 59 steps once and never carries into hours.
    preload(3, 59, 0);
    min_inc = 1'b1; step(20); min_inc = 1'b0; step();
    check8("hold_min", min_bcd, 8'h00);
    check8("hold_hour", hour_bcd, disp_bcd_hour(8'h03));

    // sec_reset edge coincident with the tick at second 59.
    preload(1, 2, 59);
    step(3);
    check1("clr_tick_before", tick_1hz, 1'b1);
    check8("clr_sec_before", sec_bcd, 8'h59);
    sec_reset = 1'b1; step(); sec_reset = 1'b0;
    check8("clr_sec", sec_bcd, 8'h00);
    check8("clr_min", min_bcd, 8'h02);
    check1("clr_tick", tick_1hz, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check1("clr_no_tick", tick_1hz, 1'b0);
    end
    step();
    check1("clr_next_tick", tick_1hz, 1'b1);

    // min_inc edge on the same cycle as the seconds carry gives one step.
    preload(10, 15, 59);
    step(3);
    min_inc = 1'b1; step(); min_inc = 1'b0;
    check8("coinc_sec", sec_bcd, 8'h00);
    check8("coinc_min", min_bcd, 8'h16);
    check8("coinc_hour", hour_bcd, disp_bcd_hour(8'h10));

`ifdef HOUR12_EN
    preload(11, 0, 0);
    check8("h12_11", hour_bcd, 8'h11);
    check1("pm_11", pm, 1'b0);
    hour_inc = 1'b1; step(); hour_inc = 1'b0;
    check8("h12_12", hour_bcd, 8'h12);
    check1("pm_12", pm, 1'b1);
    step();
    hour_inc = 1'b1; step(); hour_inc = 1'b0;
    check8("h12_13", hour_bcd, 8'h01);
    check1("pm_13", pm, 1'b1);
    do_reset();
    check8("h12_00", hour_bcd, 8'h12);
    check1("pm_00", pm, 1'b0);
`else
    preload(15, 0, 0);
    check8("h24_15", hour_bcd, 8'h15);
    check1("pm_tied", pm, 1'b0);
`endif

    // Dense random commands, then sparse ones so carries can propagate.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      sec_reset = ($urandom_range(0, 15) == 0);
      min_inc   = ($urandom_range(0, 3) == 0);
      hour_inc  = ($urandom_range(0, 3) == 0);
      step();
    end
    for (int i = 0; i < 6000; i++) begin
      sec_reset = ($urandom_range(0, 1999) == 0);
      min_inc   = ($urandom_range(0, 15) == 0);
      hour_inc  = ($urandom_range(0, 31) == 0);
      step();
    end
    sec_reset = 1'b0; min_inc = 1'b0; hour_inc = 1'b0;

    // Reset asserted mid-count clears everything asynchronously.
    step(7);
    do_reset();
    step(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
